// File: rtl/rptr_empty_pkg.sv
// Shared FIFO definitions for the read/write pointer stages: default geometry and Gray encoding.
// Used by rptr_empty (read side) and wptr_full (write side).
package rptr_empty_pkg;

   localparam int DEFAULT_ADDR_WIDTH          = 4;
   localparam int DEFAULT_ALMOST_EMPTY_THRESH = 1;
   localparam int MAX_PTR_WIDTH               = 32;

   function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
      return (bin >> 1) ^ bin;
   endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// Combinational Gray-to-binary converter of parameterized width.
// Each binary bit is the XOR of all Gray bits from the MSB down to that position.
module gray2bin #(
   parameter int WIDTH = 5
)(
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty/underflow flags of the async dual-clock FIFO.
// Optional occupancy level and almost-empty outputs are built when RPTR_LEVEL_EN is defined.
module rptr_empty
   import rptr_empty_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef RPTR_LEVEL_EN
  ,parameter int ALMOST_EMPTY_THRESH = DEFAULT_ALMOST_EMPTY_THRESH
`endif
)(
   input  logic                  r_clk,
   input  logic                  r_rstn,
   input  logic                  r_inc,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic                  r_empty,
   output logic                  r_underflow
`ifdef RPTR_LEVEL_EN
  ,output logic [ADDR_WIDTH:0]   r_level,
   output logic                  r_almost_empty
`endif
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] rbinnext;
   logic [PTR_W-1:0] rgraynext;
   logic             rd_accept;

   // A read only advances the pointer when data is actually present.
   assign rd_accept = r_inc & ~r_empty;
   assign rbinnext  = rbin + {{ADDR_WIDTH{1'b0}}, rd_accept};
   assign rgraynext = (rbinnext >> 1) ^ rbinnext;
   assign raddr     = rbin[ADDR_WIDTH-1:0];

   // Empty is judged against the next pointer so the final read flags empty on its own edge.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         rbin        <= '0;
         rptr        <= '0;
         r_empty     <= 1'b1;
         r_underflow <= 1'b0;
      end else begin
         rbin    <= rbinnext;
         rptr    <= rgraynext;
         r_empty <= (rgraynext == rq2_wptr);
         if (r_inc && r_empty)
            r_underflow <= 1'b1;
      end
   end

`ifdef RPTR_LEVEL_EN
   localparam logic [PTR_W-1:0] THRESH = PTR_W'(ALMOST_EMPTY_THRESH);

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] level_next;

   gray2bin #(
      .WIDTH (PTR_W)
   ) u_gray2bin (
      .gray (rq2_wptr),
      .bin  (wbin)
   );

   // Modular subtraction handles the wrap bit; the result lags writes by the synchronizer.
   assign level_next = wbin - rbinnext;

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_level        <= '0;
         r_almost_empty <= 1'b1;
      end else begin
         r_level        <= level_next;
         r_almost_empty <= (level_next <= THRESH);
      end
   end
`endif

endmodule
